// File: rtl/segment_display_scheduler.sv
// Multiplexed seven-segment digit scheduler: per-digit slot timing with dead time and PWM
// brightness, plus a double-buffered digit store. Optional PWM dimming: SEGMENT_DISPLAY_SCHEDULER_BRIGHTNESS_EN.
module segment_display_scheduler #(
    parameter int NUMBER_OF_DIGITS = 4,
    parameter int PRESCALE_WIDTH   = 16,
    parameter int BRIGHTNESS_WIDTH = 4,
    parameter int DEAD_CYCLES      = 2,
    localparam int IW              = $clog2(NUMBER_OF_DIGITS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PRESCALE_WIDTH-1:0]   prescale,
    input  logic [BRIGHTNESS_WIDTH-1:0] brightness,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [IW-1:0]               wr_index,
    input  logic [4:0]                  wr_data,
    input  logic                        commit_req,
    output logic                        commit_ack,
    output logic                        next_segment,
    output logic                        blank,
    output logic [IW-1:0]               digit_index,
    output logic                        frame_start,
    output logic [4:0]                  digits [0:NUMBER_OF_DIGITS-1],
    output logic [1:0]                  fsm_state
);

    typedef enum logic [1:0] {
        ST_DEAD = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int CW = PRESCALE_WIDTH + 1;
    localparam int MW = CW + BRIGHTNESS_WIDTH + 1;
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD_CYCLES);
    localparam logic [CW-1:0] MIN_L  = CW'(DEAD_CYCLES + 1);
    localparam logic [IW-1:0] LAST   = IW'(NUMBER_OF_DIGITS - 1);

    // Handshake: a back-buffer write transfers on any rising edge where wr_valid and
    // wr_ready are both high; the master must hold index/data stable while stalled.
    state_t        state;
    logic          run;
    logic          pending;
    logic [CW-1:0] c, c_plus;
    logic [CW-1:0] l_q, on_q, l_in, on_in, l_eff, on_eff, pre_plus;
    logic          first, swap, wr_fire;
    logic [4:0]    back [0:NUMBER_OF_DIGITS-1];

    assign pre_plus = {1'b0, prescale} + CW'(1);
    assign l_in     = (pre_plus > MIN_L) ? pre_plus : MIN_L;

`ifdef SEGMENT_DISPLAY_SCHEDULER_BRIGHTNESS_EN
    logic [BRIGHTNESS_WIDTH:0] duty;
    logic [MW-1:0]             product;
    assign duty    = {1'b0, brightness} + (BRIGHTNESS_WIDTH + 1)'(1);
    assign product = MW'(l_in - DEAD_C) * MW'(duty);
    assign on_in   = DEAD_C + CW'(product >> BRIGHTNESS_WIDTH);
`else
    logic brightness_unused;
    assign brightness_unused = ^brightness;
    assign on_in             = l_in;
`endif

    // Slot cycle 0 uses the live inputs; the rest of the slot uses the values captured then.
    assign first        = run && (c == '0);
    assign l_eff        = first ? l_in : l_q;
    assign on_eff       = first ? on_in : on_q;
    assign c_plus       = c + CW'(1);
    assign next_segment = run && (c == l_eff - CW'(1));
    assign swap         = next_segment && pending && (digit_index == LAST);
    assign commit_ack   = swap;
    assign wr_ready     = run && !swap;
    assign wr_fire      = wr_valid && wr_ready && ({1'b0, wr_index} < (IW + 1)'(NUMBER_OF_DIGITS));
    assign frame_start  = first && (digit_index == '0);
    assign blank        = (state != ST_ON);
    assign fsm_state    = state;

    // Slot cycle 0 is always dead time, so DEAD_CYCLES is expected to be at least 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_DEAD;
            run         <= 1'b0;
            c           <= '0;
            l_q         <= MIN_L;
            on_q        <= MIN_L;
            digit_index <= '0;
            pending     <= 1'b0;
            for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
                back[i]   <= '0;
                digits[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            if (run) begin
                if (first) begin
                    l_q  <= l_in;
                    on_q <= on_in;
                end
                if (next_segment) begin
                    c           <= '0;
                    state       <= ST_DEAD;
                    digit_index <= (digit_index == LAST) ? '0 : digit_index + IW'(1);
                end else begin
                    c <= c_plus;
                    if (c_plus < DEAD_C)       state <= ST_DEAD;
                    else if (c_plus < on_eff)  state <= ST_ON;
                    else                       state <= ST_OFF;
                end
            end
            if (wr_fire) back[wr_index] <= wr_data;
            // A request arriving on the swap cycle becomes the next pending commit.
            if (swap) begin
                pending <= commit_req;
                for (int i = 0; i < NUMBER_OF_DIGITS; i++) digits[i] <= back[i];
            end else if (commit_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
